// File: rtl/ssp_pkg.sv
// Shared definitions for the synchronous serial port TX/RX sequencers.
package ssp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    SHIFT = 2'd2
  } ssp_state_e;

  localparam int unsigned SSP_DATA_W = 8;

  // Bit-counter width for a word of w bits (never narrower than 1).
  function automatic int unsigned ssp_cnt_w(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/ssp_clkgen.sv
// Serial clock generator: divides pclk by two; fall_tick marks the pclk edge
// on which sclk falls.
module ssp_clkgen (
  input  logic pclk,
  input  logic clear,
  output logic sclk,
  output logic fall_tick
);

  logic phase_q;

  always_ff @(posedge pclk or posedge clear) begin
    if (clear) begin
      phase_q <= 1'b0;
    end else begin
      phase_q <= ~phase_q;
    end
  end

  assign sclk      = phase_q;
  assign fall_tick = phase_q;

endmodule

// File: rtl/ssp_tx_sequencer.sv
// Transmit sequencer: pops words from the TX FIFO, frames each with an FSS
// pulse and shifts it out MSB-first, updating on the falling sclk edge.
module ssp_tx_sequencer
  import ssp_pkg::*;
#(
  parameter int unsigned DATA_W = SSP_DATA_W
) (
  input  logic              PCLK,
  input  logic              CLEAR,
  input  logic              ENABLE,
  input  logic              TXFIFO_NEMPTY,
  input  logic [DATA_W-1:0] TXFIFO_DATA,
  output logic              TXFIFO_POP,
  output logic              SSPCLKOUT,
  output logic              SSPFSSOUT,
  output logic              SSPTXD,
  output logic              SSPOE_B,
  output logic              BUSY
);

  localparam int unsigned     CntW   = ssp_cnt_w(DATA_W);
  localparam logic [CntW-1:0] CntMax = CntW'(DATA_W - 1);

  ssp_state_e        state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              fss_q, fss_d;
  logic              txd_q, txd_d;
  logic              oe_b_q, oe_b_d;
  logic              fall_tick;
  logic              start;
  logic              pop;

  ssp_clkgen u_clkgen (
    .pclk      (PCLK),
    .clear     (CLEAR),
    .sclk      (SSPCLKOUT),
    .fall_tick (fall_tick)
  );

  assign start = ENABLE & TXFIFO_NEMPTY;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    fss_d   = fss_q;
    txd_d   = txd_q;
    oe_b_d  = oe_b_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall_tick && start) begin
          pop     = 1'b1;
          shift_d = TXFIFO_DATA;
          fss_d   = 1'b1;
          txd_d   = 1'b0;
          oe_b_d  = 1'b0;
          state_d = FRAME;
        end
      end
      FRAME: begin
        if (fall_tick) begin
          fss_d   = 1'b0;
          txd_d   = shift_q[DATA_W-1];
          cnt_d   = CntMax;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (fall_tick) begin
          if (cnt_q != '0) begin
            shift_d = {shift_q[DATA_W-2:0], 1'b0};
            txd_d   = shift_q[DATA_W-2];
            cnt_d   = cnt_q - CntW'(1);
          end else if (start) begin
            // Back-to-back: next frame's FSS follows the last bit directly.
            pop     = 1'b1;
            shift_d = TXFIFO_DATA;
            fss_d   = 1'b1;
            txd_d   = 1'b0;
            state_d = FRAME;
          end else begin
            txd_d   = 1'b0;
            oe_b_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        shift_d = '0;
        cnt_d   = '0;
        fss_d   = 1'b0;
        txd_d   = 1'b0;
        oe_b_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge PCLK or posedge CLEAR) begin
    if (CLEAR) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      fss_q   <= 1'b0;
      txd_q   <= 1'b0;
      oe_b_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      fss_q   <= fss_d;
      txd_q   <= txd_d;
      oe_b_q  <= oe_b_d;
    end
  end

  assign TXFIFO_POP = pop;
  assign SSPFSSOUT  = fss_q;
  assign SSPTXD     = txd_q;
  assign SSPOE_B    = oe_b_q;
  assign BUSY       = (state_q != IDLE);

endmodule
